// File: rtl/adc_mux_pkg.sv
// rtl/adc_mux_pkg.sv - FSM state encoding and select-width helper for adc_stream_mux
package adc_mux_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_PKT  = 2'd1;
  localparam state_t ST_SYNC = 2'd2;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adc_sel_sync.sv
// rtl/adc_sel_sync.sv - two-flop synchroniser for a quasi-static multi-bit select
module adc_sel_sync #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/adc_stream_mux.sv
// rtl/adc_stream_mux.sv - packet-aligned ADC source mux; switches source only between packets.
// Optional packet counter port pkt_cnt enabled by macro ADC_STREAM_MUX_PKT_CNT_EN.
module adc_stream_mux
  import adc_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int LANES  = 2,
  parameter  int DATA_W = 16,
  localparam int SEL_W  = sel_width(NUM_CH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [SEL_W-1:0]               mux_sel,
  input  logic [NUM_CH*LANES*DATA_W-1:0] in_data,
  input  logic [NUM_CH*LANES-1:0]        in_sop,
  input  logic [NUM_CH*LANES-1:0]        in_eop,
  input  logic [NUM_CH*LANES-1:0]        in_valid,
  output logic [LANES*DATA_W-1:0]        out_data,
  output logic [LANES-1:0]               out_sop,
  output logic [LANES-1:0]               out_eop,
  output logic [LANES-1:0]               out_valid,
  output logic [SEL_W-1:0]               cur_sel,
  output logic                           sel_err
`ifdef ADC_STREAM_MUX_PKT_CNT_EN
  ,
  output logic [31:0]                    pkt_cnt
`endif
);

  localparam logic [SEL_W:0] NUM_CH_V = NUM_CH[SEL_W:0];

  logic [SEL_W-1:0] sel_s2;
  logic             sel_legal;

  adc_sel_sync #(.W(SEL_W)) u_sel_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (mux_sel),
    .q     (sel_s2)
  );

  assign sel_legal = ({1'b0, sel_s2} < NUM_CH_V);

  // Per-source views of the flat input buses so the select can index them directly.
  logic [DATA_W-1:0] dat_arr [NUM_CH][LANES];
  logic [LANES-1:0]  val_arr [NUM_CH];
  logic [LANES-1:0]  sop_arr [NUM_CH];
  logic [LANES-1:0]  eop_arr [NUM_CH];

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      val_arr[c] = in_valid[c*LANES +: LANES];
      sop_arr[c] = in_sop[c*LANES +: LANES];
      eop_arr[c] = in_eop[c*LANES +: LANES];
      for (int l = 0; l < LANES; l++) begin
        dat_arr[c][l] = in_data[(c*LANES+l)*DATA_W +: DATA_W];
      end
    end
  end

  logic [DATA_W-1:0] beat_data [LANES];
  logic [LANES-1:0]  beat_val;
  logic [LANES-1:0]  beat_sop;
  logic [LANES-1:0]  beat_eop;

  assign beat_data = dat_arr[cur_sel];
  assign beat_val  = val_arr[cur_sel];
  assign beat_sop  = sop_arr[cur_sel];
  assign beat_eop  = eop_arr[cur_sel];

  state_t state;
  state_t nxt_state;
  logic   fwd;
  logic   load_sel;

  // Framing is judged on lane 0 only; the other lanes ride along.
  always_comb begin
    fwd       = 1'b0;
    load_sel  = 1'b0;
    nxt_state = state;
    case (state)
      ST_IDLE: begin
        if (sel_legal && (sel_s2 != cur_sel)) begin
          load_sel  = 1'b1;
          nxt_state = ST_SYNC;
        end else begin
          fwd = 1'b1;
          if (beat_val[0] && beat_sop[0] && !beat_eop[0]) begin
            nxt_state = ST_PKT;
          end
        end
      end
      ST_PKT: begin
        fwd = 1'b1;
        if (beat_val[0] && beat_eop[0]) begin
          nxt_state = ST_IDLE;
        end
      end
      ST_SYNC: begin
        if (beat_val[0] && beat_sop[0]) begin
          fwd       = 1'b1;
          nxt_state = beat_eop[0] ? ST_IDLE : ST_PKT;
        end
      end
      default: nxt_state = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_SYNC;
      cur_sel   <= '0;
      sel_err   <= 1'b0;
      out_data  <= '0;
      out_sop   <= '0;
      out_eop   <= '0;
      out_valid <= '0;
    end else begin
      state   <= nxt_state;
      sel_err <= !sel_legal;
      if (load_sel) begin
        cur_sel <= sel_s2;
      end
      if (fwd) begin
        out_valid <= beat_val;
        out_sop   <= beat_val & beat_sop;
        out_eop   <= beat_val & beat_eop;
      end else begin
        out_valid <= '0;
        out_sop   <= '0;
        out_eop   <= '0;
      end
      // Lanes without a valid beat keep their previous sample.
      for (int l = 0; l < LANES; l++) begin
        if (fwd && beat_val[l]) begin
          out_data[l*DATA_W +: DATA_W] <= beat_data[l];
        end
      end
    end
  end

`ifdef ADC_STREAM_MUX_PKT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
    end else if (fwd && beat_val[0] && beat_eop[0]) begin
      pkt_cnt <= pkt_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_adc_stream_mux.sv
// tb/tb_adc_stream_mux.sv - directed self-checking bench for adc_stream_mux (5 sources, 2 lanes)
module tb_adc_stream_mux;

  localparam int NUM_CH = 5;
  localparam int LANES  = 2;
  localparam int DATA_W = 16;
  localparam int SEL_W  = 3;

  logic                           clk = 1'b0;
  logic                           rst_n;
  logic [SEL_W-1:0]               mux_sel;
  logic [NUM_CH*LANES*DATA_W-1:0] in_data;
  logic [NUM_CH*LANES-1:0]        in_sop;
  logic [NUM_CH*LANES-1:0]        in_eop;
  logic [NUM_CH*LANES-1:0]        in_valid;
  logic [LANES*DATA_W-1:0]        out_data;
  logic [LANES-1:0]               out_sop;
  logic [LANES-1:0]               out_eop;
  logic [LANES-1:0]               out_valid;
  logic [SEL_W-1:0]               cur_sel;
  logic                           sel_err;
`ifdef ADC_STREAM_MUX_PKT_CNT_EN
  logic [31:0]                    pkt_cnt;
`endif

  int total = 0;
  int bad   = 0;

  adc_stream_mux #(.NUM_CH(NUM_CH), .LANES(LANES), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mux_sel   (mux_sel),
    .in_data   (in_data),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_valid (out_valid),
    .cur_sel   (cur_sel),
    .sel_err   (sel_err)
`ifdef ADC_STREAM_MUX_PKT_CNT_EN
    ,
    .pkt_cnt   (pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle sources carry valid=0 with sop/eop high and junk data, so any masking slip shows.
  task automatic idle_all();
    in_valid = '0;
    in_sop   = '1;
    in_eop   = '1;
    for (int i = 0; i < NUM_CH*LANES; i++) in_data[i*DATA_W +: DATA_W] = 16'hDEAD;
  endtask

  task automatic put(input int c, input logic s, input logic e, input logic [15:0] d);
    for (int l = 0; l < LANES; l++) begin
      in_valid[c*LANES+l] = 1'b1;
      in_sop[c*LANES+l]   = s;
      in_eop[c*LANES+l]   = e;
      in_data[(c*LANES+l)*DATA_W +: DATA_W] = d + 16'(l);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    mux_sel = '0;
    idle_all();
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", out_data, 32'h0);
    check("rst_cur_sel", 32'(cur_sel), 32'h0);
    check("rst_sel_err", 32'(sel_err), 32'h0);
    rst_n = 1'b1;

    // Beat without sop after reset is suppressed, then an 8-beat packet passes.
    idle_all(); put(0, 1'b0, 1'b0, 16'h0100);
    tick();
    check("first_nosop_valid", 32'(out_valid), 32'h0);
    for (int k = 0; k < 8; k++) begin
      idle_all(); put(0, k == 0, k == 7, 16'(16'h0200 + 2*k));
      tick();
      check("p1_valid", 32'(out_valid), 32'h3);
      check("p1_sop", 32'(out_sop), (k == 0) ? 32'h3 : 32'h0);
      check("p1_eop", 32'(out_eop), (k == 7) ? 32'h3 : 32'h0);
      check("p1_data", out_data, {16'(16'h0201 + 2*k), 16'(16'h0200 + 2*k)});
    end
    idle_all();
    tick();
    check("gap_valid", 32'(out_valid), 32'h0);
    check("gap_sop", 32'(out_sop), 32'h0);
    check("gap_data_hold", out_data, 32'h020F_020E);
    check("p1_cur_sel", 32'(cur_sel), 32'h0);

    // Select change mid-packet waits for eop.
    for (int k = 0; k < 8; k++) begin
      idle_all(); put(0, k == 0, k == 7, 16'(16'h0A00 + 2*k));
      if (k == 3) mux_sel = 3'd2;
      tick();
      check("p2_valid", 32'(out_valid), 32'h3);
      check("p2_data", out_data, {16'(16'h0A01 + 2*k), 16'(16'h0A00 + 2*k)});
    end
    check("p2_cur_sel_at_eop", 32'(cur_sel), 32'h0);
    idle_all();
    tick();
    check("sw_cur_sel", 32'(cur_sel), 32'h2);
    check("sw_valid", 32'(out_valid), 32'h0);
    tick();
    check("sync_valid", 32'(out_valid), 32'h0);
    check("sync_eop", 32'(out_eop), 32'h0);
    idle_all(); put(2, 1'b1, 1'b0, 16'h0300);
    tick();
    check("s2_sop_valid", 32'(out_valid), 32'h3);
    check("s2_sop", 32'(out_sop), 32'h3);
    check("s2_sop_data", out_data, 32'h0301_0300);
    idle_all(); put(2, 1'b0, 1'b1, 16'h0302);
    tick();
    check("s2_eop", 32'(out_eop), 32'h3);
    check("s2_eop_sop", 32'(out_sop), 32'h0);

    // Illegal select.
    idle_all(); put(2, 1'b0, 1'b0, 16'h0400);
    mux_sel = 3'd5;
    tick();
    check("err_c1", 32'(sel_err), 32'h0);
    tick();
    check("err_c2", 32'(sel_err), 32'h0);
    tick();
    check("err_c3", 32'(sel_err), 32'h1);
    check("err_cur_sel", 32'(cur_sel), 32'h2);
    check("err_valid", 32'(out_valid), 32'h3);
    check("err_data", out_data, 32'h0401_0400);

    // Back to a legal select, then single-beat packets with a 1 -> 3 switch.
    mux_sel = 3'd1;
    idle_all(); put(1, 1'b1, 1'b1, 16'h0500);
    tick();
    check("to1_c1_valid", 32'(out_valid), 32'h0);
    tick();
    tick();
    check("to1_cur_sel", 32'(cur_sel), 32'h1);
    check("to1_sel_err", 32'(sel_err), 32'h0);
    check("to1_valid", 32'(out_valid), 32'h0);
    tick();
    check("s1_valid", 32'(out_valid), 32'h3);
    check("s1_sopeop", 32'({out_sop, out_eop}), 32'hF);
    check("s1_data", out_data, 32'h0501_0500);
    mux_sel = 3'd3;
    for (int k = 0; k < 5; k++) begin
      idle_all();
      put(1, 1'b1, 1'b1, 16'(16'h0600 + 2*k));
      put(3, 1'b1, 1'b1, 16'(16'h0700 + 2*k));
      tick();
      case (k)
        0, 1: begin
          check("sb_src1_data", out_data, {16'(16'h0601 + 2*k), 16'(16'h0600 + 2*k)});
          check("sb_src1_valid", 32'(out_valid), 32'h3);
        end
        2: begin
          check("sb_drop_valid", 32'(out_valid), 32'h0);
          check("sb_cur_sel", 32'(cur_sel), 32'h3);
        end
        default: begin
          check("sb_src3_data", out_data, {16'(16'h0701 + 2*k), 16'(16'h0700 + 2*k)});
          check("sb_src3_sopeop", 32'({out_sop, out_eop}), 32'hF);
        end
      endcase
    end

    // Reset mid-packet.
    idle_all(); put(3, 1'b1, 1'b0, 16'h0800);
    tick();
    check("pr_sop", 32'(out_sop), 32'h3);
    idle_all(); put(3, 1'b0, 1'b0, 16'h0802);
    tick();
    check("pr_mid_data", out_data, 32'h0803_0802);
    rst_n   = 1'b0;
    mux_sel = 3'd0;
    #1;
    check("ar_valid", 32'(out_valid), 32'h0);
    check("ar_data", out_data, 32'h0);
    check("ar_cur_sel", 32'(cur_sel), 32'h0);
    tick();
    rst_n = 1'b1;
    idle_all(); put(3, 1'b0, 1'b0, 16'h0804); put(0, 1'b0, 1'b0, 16'h0810);
    tick();
    check("post_rst_mid_valid", 32'(out_valid), 32'h0);
    idle_all(); put(3, 1'b0, 1'b1, 16'h0806); put(0, 1'b0, 1'b1, 16'h0812);
    tick();
    check("post_rst_eop_valid", 32'(out_valid), 32'h0);
    check("post_rst_eop", 32'(out_eop), 32'h0);
    check("post_rst_data", out_data, 32'h0);
    idle_all(); put(0, 1'b1, 1'b1, 16'h0900);
    tick();
    check("post_rst_sop_valid", 32'(out_valid), 32'h3);
    check("post_rst_sopeop", 32'({out_sop, out_eop}), 32'hF);
    check("post_rst_data2", out_data, 32'h0901_0900);

`ifdef ADC_STREAM_MUX_PKT_CNT_EN
    force dut.pkt_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.pkt_cnt;
    idle_all(); put(0, 1'b1, 1'b1, 16'h0A00);
    tick();
    check("pkt_cnt_wrap", pkt_cnt, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
